rgstr_file: RTL and testbench

//  Parametrised register file: NREGS words of WIDTH bits, one masked write port,
//  two registered read ports with write-to-read bypass, plus a per-register

---
 rtl/bitty_pkg.sv | 28 ++
 rtl/rgstr_file_rport.sv | 62 ++++++
 rtl/rgstr_file.sv | 90 +++++++++
 tb/tb_rgstr_file.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bitty_pkg.sv
// Shared constants and helpers for the bitty register file.
//   WIDTH_DEF / NREGS_DEF : default word width and register count
//   NIB                   : nibbles per default-width word
//   nib_merge()           : nibble-masked merge of a new word over an old one
package bitty_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int NREGS_DEF = 8;
  localparam int NIB       = WIDTH_DEF / 4;

  // nib_merge works on a fixed wide word so any WIDTH up to MERGE_W can use it
  // by zero-extending its operands and truncating the result.
  localparam int MERGE_W   = 64;

  function automatic logic [MERGE_W-1:0] nib_merge(
    input logic [MERGE_W-1:0]   old_w,
    input logic [MERGE_W-1:0]   new_w,
    input logic [MERGE_W/4-1:0] mask
  );
    logic [MERGE_W-1:0] res;
    res = old_w;
    for (int k = 0; k < MERGE_W / 4; k++) begin
      if (mask[k]) res[4*k +: 4] = new_w[4*k +: 4];
    end
    return res;
  endfunction

endpackage

// File: rtl/rgstr_file_rport.sv
// One registered read port of rgstr_file.
//   raddr_i            read address, sampled every rising edge
//   regs_i / busy_i    current storage contents and busy vector
//   wr_ok_i, waddr_i,  qualified write this cycle and its merged data
//   wr_data_i
//   lk_ok_i, lk_addr_i qualified lock this cycle
//   rdata_o / busy_o   registered read result (post-update view of raddr_i)
module rgstr_file_rport
  import bitty_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int NREGS   = NREGS_DEF,
  parameter int AW      = $clog2(NREGS),
  parameter bit ZERO_R0 = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    raddr_i,
  input  logic [WIDTH-1:0] regs_i [NREGS],
  input  logic [NREGS-1:0] busy_i,
  input  logic             wr_ok_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             lk_ok_i,
  input  logic [AW-1:0]    lk_addr_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             busy_o
);

  logic [WIDTH-1:0] rdata_d, rdata_q;
  logic             busy_d, busy_q;

  // The output register is loaded with the value the addressed register will
  // hold after this edge, so a same-cycle write/lock is visible immediately.
  always_comb begin
    rdata_d = '0;
    busy_d  = 1'b0;
    if ((32'(raddr_i) < NREGS) && !(ZERO_R0 && (raddr_i == '0))) begin
      rdata_d = regs_i[raddr_i];
      busy_d  = busy_i[raddr_i];
      if (wr_ok_i && (waddr_i == raddr_i)) begin
        rdata_d = wr_data_i;
        busy_d  = 1'b0;
      end
      if (lk_ok_i && (lk_addr_i == raddr_i)) busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
    end
  end

  assign rdata_o = rdata_q;
  assign busy_o  = busy_q;

endmodule

// File: rtl/rgstr_file.sv
// Register file: NREGS x WIDTH storage, one nibble-masked write port, two
// registered read ports with write-to-read bypass, per-register busy bits.
//   clk, reset               clock, async active-high reset
//   we_i/waddr_i/wdata_i/    masked write
//   wmask_i
//   lock_i/lock_addr_i       set busy on a register
//   raddr_a_i / raddr_b_i    read addresses
//   rdata_a_o/b_o,           registered read data and busy bits
//   busy_a_o/b_o
module rgstr_file
  import bitty_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int NREGS   = NREGS_DEF,
  parameter int AW      = $clog2(NREGS),
  parameter bit ZERO_R0 = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               we_i,
  input  logic [AW-1:0]      waddr_i,
  input  logic [WIDTH-1:0]   wdata_i,
  input  logic [WIDTH/4-1:0] wmask_i,
  input  logic               lock_i,
  input  logic [AW-1:0]      lock_addr_i,
  input  logic [AW-1:0]      raddr_a_i,
  input  logic [AW-1:0]      raddr_b_i,
  output logic [WIDTH-1:0]   rdata_a_o,
  output logic [WIDTH-1:0]   rdata_b_o,
  output logic               busy_a_o,
  output logic               busy_b_o
);

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic             wr_ok, lk_ok;
  logic [WIDTH-1:0] wr_old, wr_merged;

  // Writes/locks beyond NREGS, or to r0 when it is hardwired, are dropped here
  // so storage and both read ports see only qualified updates.
  always_comb begin
    wr_ok     = we_i && (32'(waddr_i) < NREGS) && !(ZERO_R0 && (waddr_i == '0));
    lk_ok     = lock_i && (32'(lock_addr_i) < NREGS) && !(ZERO_R0 && (lock_addr_i == '0));
    wr_old    = (32'(waddr_i) < NREGS) ? regs_q[waddr_i] : '0;
    wr_merged = WIDTH'(nib_merge(MERGE_W'(wr_old), MERGE_W'(wdata_i), (MERGE_W/4)'(wmask_i)));
  end

  // Lock is applied after the write so a same-cycle lock leaves busy set.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wr_ok) begin
      regs_d[waddr_i] = wr_merged;
      busy_d[waddr_i] = 1'b0;
    end
    if (lk_ok) busy_d[lock_addr_i] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs_q <= '{default: '0};
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  rgstr_file_rport #(
    .WIDTH(WIDTH), .NREGS(NREGS), .AW(AW), .ZERO_R0(ZERO_R0)
  ) u_rport_a (
    .clk(clk), .reset(reset), .raddr_i(raddr_a_i),
    .regs_i(regs_q), .busy_i(busy_q),
    .wr_ok_i(wr_ok), .waddr_i(waddr_i), .wr_data_i(wr_merged),
    .lk_ok_i(lk_ok), .lk_addr_i(lock_addr_i),
    .rdata_o(rdata_a_o), .busy_o(busy_a_o)
  );

  rgstr_file_rport #(
    .WIDTH(WIDTH), .NREGS(NREGS), .AW(AW), .ZERO_R0(ZERO_R0)
  ) u_rport_b (
    .clk(clk), .reset(reset), .raddr_i(raddr_b_i),
    .regs_i(regs_q), .busy_i(busy_q),
    .wr_ok_i(wr_ok), .waddr_i(waddr_i), .wr_data_i(wr_merged),
    .lk_ok_i(lk_ok), .lk_addr_i(lock_addr_i),
    .rdata_o(rdata_b_o), .busy_o(busy_b_o)
  );

endmodule

// File: tb/tb_rgstr_file.sv
// Bench for rgstr_file. Three instances share one stimulus stream:
//   dut 0 : defaults (8 regs), dut 1 : ZERO_R0=1, dut 2 : NREGS=6.
module tb_rgstr_file;
  import bitty_pkg::*;

  logic           clk = 1'b0;
  logic           reset;
  logic           we;
  logic [2:0]     waddr;
  logic [15:0]    wdata;
  logic [NIB-1:0] wmask;
  logic           lock;
  logic [2:0]     lock_addr;
  logic [2:0]     raddr_a, raddr_b;

  logic [15:0] rd_a0, rd_b0, rd_a1, rd_b1, rd_a2, rd_b2;
  logic        bz_a0, bz_b0, bz_a1, bz_b1, bz_a2, bz_b2;

  always #5 clk = ~clk;

  rgstr_file u_dut0 (
    .clk(clk), .reset(reset), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
    .wmask_i(wmask), .lock_i(lock), .lock_addr_i(lock_addr),
    .raddr_a_i(raddr_a), .raddr_b_i(raddr_b),
    .rdata_a_o(rd_a0), .rdata_b_o(rd_b0), .busy_a_o(bz_a0), .busy_b_o(bz_b0)
  );

  rgstr_file #(.ZERO_R0(1'b1)) u_dut1 (
    .clk(clk), .reset(reset), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
    .wmask_i(wmask), .lock_i(lock), .lock_addr_i(lock_addr),
    .raddr_a_i(raddr_a), .raddr_b_i(raddr_b),
    .rdata_a_o(rd_a1), .rdata_b_o(rd_b1), .busy_a_o(bz_a1), .busy_b_o(bz_b1)
  );

  rgstr_file #(.NREGS(6)) u_dut2 (
    .clk(clk), .reset(reset), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
    .wmask_i(wmask), .lock_i(lock), .lock_addr_i(lock_addr),
    .raddr_a_i(raddr_a), .raddr_b_i(raddr_b),
    .rdata_a_o(rd_a2), .rdata_b_o(rd_b2), .busy_a_o(bz_a2), .busy_b_o(bz_b2)
  );

  typedef struct {
    string       nm;
    int          dut;
    int          port;
    logic [15:0] d;
    logic        b;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] od;
  logic        ob;

  logic [15:0] m_reg  [8];
  logic        m_busy [8];

  function automatic logic [15:0] obs_d(input int dut, input int port);
    case (dut)
      0:       return (port == 0) ? rd_a0 : rd_b0;
      1:       return (port == 0) ? rd_a1 : rd_b1;
      default: return (port == 0) ? rd_a2 : rd_b2;
    endcase
  endfunction

  function automatic logic obs_b(input int dut, input int port);
    case (dut)
      0:       return (port == 0) ? bz_a0 : bz_b0;
      1:       return (port == 0) ? bz_a1 : bz_b1;
      default: return (port == 0) ? bz_a2 : bz_b2;
    endcase
  endfunction

  task automatic push(input string nm, input int dut, input int port,
                      input logic [15:0] d, input logic b);
    sb.push_back('{nm, dut, port, d, b});
  endtask

  task automatic idle();
    we = 1'b0; waddr = '0; wdata = '0; wmask = '0;
    lock = 1'b0; lock_addr = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    raddr_a = '0; raddr_b = '0;
    #1;
    for (int d = 0; d < 3; d++) begin
      for (int p = 0; p < 2; p++) begin
        n_vec++;
        if (obs_d(d, p) !== 16'h0000 || obs_b(d, p) !== 1'b0) begin
          n_err++;
          $display("FAIL reset_init dut%0d port%0d: got %h/%b want 0000/0", d, p, obs_d(d, p), obs_b(d, p));
        end
      end
    end
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_write();
    for (int c = 0; c < 3; c++) begin
      idle();
      case (c)
        0: begin
          we = 1'b1; waddr = 3'd3; wdata = 16'hBEEF; wmask = 4'hF;
          raddr_a = 3'd0; raddr_b = 3'd1;
          push("wr_r0_before", 0, 0, 16'h0000, 1'b0);
        end
        1: begin
          raddr_a = 3'd3;
          push("wr_r3_a", 0, 0, 16'hBEEF, 1'b0);
          push("wr_r3_a_z", 1, 0, 16'hBEEF, 1'b0);
          push("wr_r3_a_6", 2, 0, 16'hBEEF, 1'b0);
        end
        default: begin
          raddr_a = 3'd3; raddr_b = 3'd3;
          push("wr_r3_hold_a", 0, 0, 16'hBEEF, 1'b0);
          push("wr_r3_hold_b", 0, 1, 16'hBEEF, 1'b0);
        end
      endcase
      tick();
      while (sb.size() > 0) begin
        e = sb.pop_front(); n_vec++;
        od = obs_d(e.dut, e.port); ob = obs_b(e.dut, e.port);
        if (od !== e.d || ob !== e.b) begin
          n_err++;
          $display("FAIL %s dut%0d port%0d: got %h/%b want %h/%b", e.nm, e.dut, e.port, od, ob, e.d, e.b);
        end
      end
    end
  endtask

  task automatic test_bypass();
    for (int c = 0; c < 2; c++) begin
      idle();
      if (c == 0) begin
        we = 1'b1; waddr = 3'd3; wdata = 16'h1234; wmask = 4'b0101;
        raddr_b = 3'd3; raddr_a = 3'd1;
        push("byp_r3_b", 0, 1, 16'hB2E4, 1'b0);
        push("byp_r3_b_z", 1, 1, 16'hB2E4, 1'b0);
        push("byp_r1_a", 0, 0, 16'h0000, 1'b0);
      end else begin
        raddr_a = 3'd3;
        push("byp_r3_store", 0, 0, 16'hB2E4, 1'b0);
      end
      tick();
      while (sb.size() > 0) begin
        e = sb.pop_front(); n_vec++;
        od = obs_d(e.dut, e.port); ob = obs_b(e.dut, e.port);
        if (od !== e.d || ob !== e.b) begin
          n_err++;
          $display("FAIL %s dut%0d port%0d: got %h/%b want %h/%b", e.nm, e.dut, e.port, od, ob, e.d, e.b);
        end
      end
    end
  endtask

  task automatic test_lock();
    for (int c = 0; c < 9; c++) begin
      idle();
      raddr_a = 3'd5; raddr_b = 3'd5;
      case (c)
        0: begin
          lock = 1'b1; lock_addr = 3'd5;
          push("lk_set_a", 0, 0, 16'h0000, 1'b1);
          push("lk_set_b", 0, 1, 16'h0000, 1'b1);
        end
        1: push("lk_hold", 0, 0, 16'h0000, 1'b1);
        2: begin
          we = 1'b1; waddr = 3'd5; wdata = 16'h5A5A; wmask = 4'hF;
          push("lk_wr_clear", 0, 0, 16'h5A5A, 1'b0);
        end
        3: begin
          push("lk_clear_a", 0, 0, 16'h5A5A, 1'b0);
          push("lk_clear_b", 0, 1, 16'h5A5A, 1'b0);
        end
        4: begin
          we = 1'b1; waddr = 3'd5; wdata = 16'hC3C3; wmask = 4'b0011;
          lock = 1'b1; lock_addr = 3'd5;
          push("lk_and_wr", 0, 0, 16'h5AC3, 1'b1);
        end
        5: push("lk_and_wr_hold", 0, 0, 16'h5AC3, 1'b1);
        6: begin
          we = 1'b1; waddr = 3'd5; wdata = 16'hFFFF; wmask = 4'h0;
          push("lk_mask0_clear", 0, 0, 16'h5AC3, 1'b0);
        end
        7: begin
          lock = 1'b1; lock_addr = 3'd4; raddr_b = 3'd4;
          push("lk_other_a", 0, 0, 16'h5AC3, 1'b0);
          push("lk_r4_b", 0, 1, 16'h0000, 1'b1);
        end
        default: begin
          we = 1'b1; waddr = 3'd4; wdata = 16'h4444; wmask = 4'hF;
          lock = 1'b1; lock_addr = 3'd5; raddr_b = 3'd4;
          push("lk_split_a", 0, 0, 16'h5AC3, 1'b1);
          push("lk_split_b", 0, 1, 16'h4444, 1'b0);
        end
      endcase
      tick();
      while (sb.size() > 0) begin
        e = sb.pop_front(); n_vec++;
        od = obs_d(e.dut, e.port); ob = obs_b(e.dut, e.port);
        if (od !== e.d || ob !== e.b) begin
          n_err++;
          $display("FAIL %s dut%0d port%0d: got %h/%b want %h/%b", e.nm, e.dut, e.port, od, ob, e.d, e.b);
        end
      end
    end
  endtask

  task automatic test_zero_r0();
    for (int c = 0; c < 4; c++) begin
      idle();
      raddr_a = 3'd0; raddr_b = 3'd1;
      case (c)
        0: begin
          we = 1'b1; waddr = 3'd0; wdata = 16'hFFFF; wmask = 4'hF;
          lock = 1'b1; lock_addr = 3'd0;
          push("z_r0_byp", 1, 0, 16'h0000, 1'b0);
          push("z_r1_b", 1, 1, 16'h0000, 1'b0);
          push("nz_r0_byp", 0, 0, 16'hFFFF, 1'b1);
        end
        1: begin
          push("z_r0_read", 1, 0, 16'h0000, 1'b0);
          push("nz_r0_read", 0, 0, 16'hFFFF, 1'b1);
        end
        2: begin
          we = 1'b1; waddr = 3'd1; wdata = 16'h1111; wmask = 4'hF;
          lock = 1'b1; lock_addr = 3'd1;
          push("z_r1_byp", 1, 1, 16'h1111, 1'b1);
        end
        default: begin
          push("z_r0_again", 1, 0, 16'h0000, 1'b0);
          push("z_r1_read", 1, 1, 16'h1111, 1'b1);
        end
      endcase
      tick();
      while (sb.size() > 0) begin
        e = sb.pop_front(); n_vec++;
        od = obs_d(e.dut, e.port); ob = obs_b(e.dut, e.port);
        if (od !== e.d || ob !== e.b) begin
          n_err++;
          $display("FAIL %s dut%0d port%0d: got %h/%b want %h/%b", e.nm, e.dut, e.port, od, ob, e.d, e.b);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    idle();
    raddr_a = 3'd0; raddr_b = 3'd5;
    #2;
    reset = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      for (int p = 0; p < 2; p++) begin
        n_vec++;
        if (obs_d(d, p) !== 16'h0000 || obs_b(d, p) !== 1'b0) begin
          n_err++;
          $display("FAIL reset_mid dut%0d port%0d: got %h/%b want 0000/0", d, p, obs_d(d, p), obs_b(d, p));
        end
      end
    end
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      raddr_a = 3'(i); raddr_b = 3'(7 - i);
      push("rst_rd_a", 0, 0, 16'h0000, 1'b0);
      push("rst_rd_b", 0, 1, 16'h0000, 1'b0);
      push("rst_rd_a_z", 1, 0, 16'h0000, 1'b0);
      tick();
      while (sb.size() > 0) begin
        e = sb.pop_front(); n_vec++;
        od = obs_d(e.dut, e.port); ob = obs_b(e.dut, e.port);
        if (od !== e.d || ob !== e.b) begin
          n_err++;
          $display("FAIL %s dut%0d port%0d addr%0d: got %h/%b want %h/%b", e.nm, e.dut, e.port, i, od, ob, e.d, e.b);
        end
      end
    end
  endtask

  task automatic test_nregs6();
    for (int c = 0; c < 14; c++) begin
      idle();
      if (c < 6) begin
        we = 1'b1; waddr = 3'(c); wdata = 16'(16'h1111 * (c + 1)); wmask = 4'hF;
        raddr_a = 3'(c); raddr_b = 3'd7;
        push("n6_fill_byp", 2, 0, 16'(16'h1111 * (c + 1)), 1'b0);
      end else if (c < 8) begin
        we = 1'b1; waddr = (c == 6) ? 3'd7 : 3'd6; wdata = 16'hAAAA; wmask = 4'hF;
        lock = 1'b1; lock_addr = waddr;
        raddr_a = 3'd7; raddr_b = 3'd6;
        push("n6_oob7", 2, 0, 16'h0000, 1'b0);
        push("n6_oob6", 2, 1, 16'h0000, 1'b0);
        if (c == 6) push("n8_r7_ok", 0, 0, 16'hAAAA, 1'b1);
      end else begin
        raddr_a = 3'(c - 8); raddr_b = 3'(c - 8);
        push("n6_keep_a", 2, 0, 16'(16'h1111 * (c - 7)), 1'b0);
        push("n6_keep_b", 2, 1, 16'(16'h1111 * (c - 7)), 1'b0);
      end
      tick();
      while (sb.size() > 0) begin
        e = sb.pop_front(); n_vec++;
        od = obs_d(e.dut, e.port); ob = obs_b(e.dut, e.port);
        if (od !== e.d || ob !== e.b) begin
          n_err++;
          $display("FAIL %s dut%0d port%0d cyc%0d: got %h/%b want %h/%b", e.nm, e.dut, e.port, c, od, ob, e.d, e.b);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] v;
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int r = 0; r < 8; r++) begin
      m_reg[r] = '0; m_busy[r] = 1'b0;
    end
    for (int c = 0; c < 60; c++) begin
      we        = 1'($urandom_range(0, 1));
      waddr     = 3'($urandom_range(0, 7));
      wdata     = 16'($urandom);
      wmask     = 4'($urandom_range(0, 15));
      lock      = ($urandom_range(0, 2) == 0);
      lock_addr = ($urandom_range(0, 1) == 0) ? waddr : 3'($urandom_range(0, 7));
      raddr_a   = ($urandom_range(0, 1) == 0) ? waddr : 3'($urandom_range(0, 7));
      raddr_b   = 3'($urandom_range(0, 7));
      if (we) begin
        v = m_reg[waddr];
        for (int k = 0; k < 4; k++) if (wmask[k]) v[4*k +: 4] = wdata[4*k +: 4];
        m_reg[waddr]  = v;
        m_busy[waddr] = 1'b0;
      end
      if (lock) m_busy[lock_addr] = 1'b1;
      push("b2b_a", 0, 0, m_reg[raddr_a], m_busy[raddr_a]);
      push("b2b_b", 0, 1, m_reg[raddr_b], m_busy[raddr_b]);
      tick();
      while (sb.size() > 0) begin
        e = sb.pop_front(); n_vec++;
        od = obs_d(e.dut, e.port); ob = obs_b(e.dut, e.port);
        if (od !== e.d || ob !== e.b) begin
          n_err++;
          $display("FAIL %s cyc%0d port%0d: got %h/%b want %h/%b", e.nm, c, e.port, od, ob, e.d, e.b);
        end
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_write();
    test_bypass();
    test_lock();
    test_zero_r0();
    test_reset_mid();
    test_nregs6();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded 100000 time units");
    $fatal(1, "timeout");
  end

endmodule
